// File: rtl/cv32e40p_obi_mo_interface.sv
// OBI master adapter with up to MAX_OUTSTANDING in-flight transactions.
// Holds the address phase stable until it is granted and keeps a FIFO of the
// we bit of each accepted transaction, so every response carries its we.
module cv32e40p_obi_mo_interface #(
  parameter int unsigned TRANS_STABLE    = 0,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned BE_W  = DATA_WIDTH / 8,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Transaction port
  input  logic                  trans_valid_i,
  output logic                  trans_ready_o,
  input  logic [ADDR_WIDTH-1:0] trans_addr_i,
  input  logic                  trans_we_i,
  input  logic [BE_W-1:0]       trans_be_i,
  input  logic [DATA_WIDTH-1:0] trans_wdata_i,
  input  logic [5:0]            trans_atop_i,
  // Response port
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  resp_we_o,
  // OBI bus
  output logic                  obi_req_o,
  input  logic                  obi_gnt_i,
  output logic [ADDR_WIDTH-1:0] obi_addr_o,
  output logic                  obi_we_o,
  output logic [BE_W-1:0]       obi_be_o,
  output logic [DATA_WIDTH-1:0] obi_wdata_o,
  output logic [5:0]            obi_atop_o,
  input  logic [DATA_WIDTH-1:0] obi_rdata_i,
  input  logic                  obi_rvalid_i,
  input  logic                  obi_err_i,
  // Status
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  idle_o,
  output logic                  proto_err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {StTransparent, StRegistered} state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   we_q;
  logic [BE_W-1:0]        be_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [5:0]             atop_q;

  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PTR_W-1:0]           wptr_q, rptr_q;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       proto_err_q;

  logic full, accept, pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Request path: pass-through or held address phase; full uses registered count only
  always_comb begin
    full          = (count_q == CNT_W'(MAX_OUTSTANDING));
    obi_addr_o    = trans_addr_i;
    obi_we_o      = trans_we_i;
    obi_be_o      = trans_be_i;
    obi_wdata_o   = trans_wdata_i;
    obi_atop_o    = trans_atop_i;
    obi_req_o     = trans_valid_i && !full;
    trans_ready_o = !full;
    if (TRANS_STABLE != 0) begin
      trans_ready_o = obi_gnt_i && !full;
    end else if (state_q == StRegistered) begin
      obi_addr_o    = addr_q;
      obi_we_o      = we_q;
      obi_be_o      = be_q;
      obi_wdata_o   = wdata_q;
      obi_atop_o    = atop_q;
      obi_req_o     = 1'b1;
      trans_ready_o = 1'b0;
    end
  end

  // Response path and outstanding bookkeeping
  always_comb begin
    accept  = obi_req_o && obi_gnt_i;
    pop     = obi_rvalid_i && (count_q != '0);
    count_d = count_q;
    if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    resp_valid_o  = obi_rvalid_i;
    resp_rdata_o  = obi_rdata_i;
    resp_err_o    = obi_err_i;
    resp_we_o     = pop ? fifo_q[rptr_q] : 1'b0;
    outstanding_o = count_q;
    idle_o        = (count_q == '0) && !obi_req_o;
    proto_err_o   = proto_err_q;
  end

  // Address-phase FSM: capture an ungranted request and hold it until granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StTransparent;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      atop_q  <= '0;
    end else begin
      unique case (state_q)
        StTransparent: begin
          if ((TRANS_STABLE == 0) && obi_req_o && !obi_gnt_i) begin
            state_q <= StRegistered;
            addr_q  <= trans_addr_i;
            we_q    <= trans_we_i;
            be_q    <= trans_be_i;
            wdata_q <= trans_wdata_i;
            atop_q  <= trans_atop_i;
          end
        end
        StRegistered: begin
          if (obi_gnt_i) state_q <= StTransparent;
        end
        default: state_q <= StTransparent;
      endcase
    end
  end

  // Tag FIFO, counter and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) begin
        fifo_q[wptr_q] <= obi_we_o;
        wptr_q         <= ptr_next(wptr_q);
      end
      if (pop) rptr_q <= ptr_next(rptr_q);
      count_q <= count_d;
      // A response with nothing outstanding cannot be matched to a request
      if (obi_rvalid_i && (count_q == '0)) proto_err_q <= 1'b1;
    end
  end

endmodule
